program_memory_param: RTL

PROGRAM_MEMORY_PARAM -- requirements
Module: program_memory_param

---
 rtl/program_memory_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/program_memory_param.sv
`timescale 1ns/1ps
// Program memory with an instruction fetch port and a data load port.
// Both share one registered read port; data loads win arbitration.
module program_memory_param #(
    parameter int unsigned DEPTH_WORDS      = 3072,
    parameter string       INIT_FILE        = "./../memory/flash.txt",
    parameter bit          BIG_ENDIAN_IMAGE = 1'b1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_req,
    input  logic [31:0]      instr_addr,
    output logic [31:0]      instr_data,
    output logic             instr_valid,
    input  logic             data_req,
    input  logic [31:0]      data_addr,
    input  logic [1:0]       data_width,
    input  logic             data_signed,
    output logic [31:0]      data_rdata,
    output logic             data_valid,
    output logic             data_err,
    output logic [CNT_W-1:0] conflict_count
);

    localparam int unsigned ADDR_W =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_e;

    logic [31:0] rom_mem [DEPTH_WORDS];

    state_e             state_q, state_d;
    logic [31:0]        rd_word_q;
    logic               oob_q, oob_d;
    logic               err_q, err_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         width_q, width_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        instr_hold_q, instr_hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        rd_addr;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_oob;
    logic               rd_en;
    logic [31:0]        word_le;
    logic [31:0]        fetch_word;
    logic [15:0]        half;
    logic [7:0]         byte_sel;
    logic [31:0]        fmt;

    function automatic logic [31:0] to_le(input logic [31:0] w);
        if (BIG_ENDIAN_IMAGE)
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        return w;
    endfunction

    always_comb begin
        rd_addr = data_req ? data_addr : instr_addr;
        rd_idx  = rd_addr[ADDR_W+1:2];
        rd_oob  = {2'b00, rd_addr[31:2]} >= 32'(DEPTH_WORDS);
        rd_en   = reset & (data_req | instr_req) & ~rd_oob;
    end

    // Read register only; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rd_en) rd_word_q <= rom_mem[rd_idx];
    end

    always_comb begin
        state_d      = IDLE;
        oob_d        = rd_oob;
        off_d        = data_addr[1:0];
        width_d      = data_width;
        sgn_d        = data_signed;
        err_d        = rd_oob;
        instr_hold_d = instr_hold_q;
        cnt_d        = cnt_q;
        if (data_req) begin
            state_d = DATA;
        end else if (instr_req) begin
            state_d = INSTR;
        end
        unique case (data_width)
            2'b00:   err_d = rd_oob | (data_addr[1:0] != 2'b00);
            2'b01:   err_d = rd_oob | (data_addr[1:0] == 2'b11);
            2'b10:   err_d = rd_oob;
            default: err_d = 1'b1;
        endcase
        if (state_q == INSTR) instr_hold_d = fetch_word;
        if (data_req && instr_req && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
        if (!reset) begin
            state_d      = IDLE;
            instr_hold_d = '0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            oob_q        <= 1'b0;
            err_q        <= 1'b0;
            off_q        <= 2'b00;
            width_q      <= 2'b00;
            sgn_q        <= 1'b0;
            instr_hold_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            oob_q        <= oob_d;
            err_q        <= err_d;
            off_q        <= off_d;
            width_q      <= width_d;
            sgn_q        <= sgn_d;
            instr_hold_q <= instr_hold_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        word_le    = to_le(rd_word_q);
        fetch_word = oob_q ? NOP : word_le;
        half       = word_le[31:16];
        byte_sel   = word_le[31:24];
        fmt        = '0;
        unique case (off_q)
            2'b00: begin
                half     = word_le[15:0];
                byte_sel = word_le[7:0];
            end
            2'b01: begin
                half     = word_le[23:8];
                byte_sel = word_le[15:8];
            end
            2'b10: begin
                half     = word_le[31:16];
                byte_sel = word_le[23:16];
            end
            default: begin
                half     = word_le[31:16];
                byte_sel = word_le[31:24];
            end
        endcase
        unique case (width_q)
            2'b00:   fmt = word_le;
            2'b01:   fmt = {{16{sgn_q & half[15]}}, half};
            2'b10:   fmt = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            default: fmt = '0;
        endcase
    end

    assign instr_valid    = (state_q == INSTR);
    assign instr_data     = instr_valid ? fetch_word : instr_hold_q;
    assign data_valid     = (state_q == DATA);
    assign data_err       = data_valid & err_q;
    assign data_rdata     = (data_valid && !err_q) ? fmt : 32'h0;
    assign conflict_count = cnt_q;

endmodule
